// File: rtl/branch_resolve_unit_pkg.sv
// Shared constants for the branch resolve unit, the BTB and the fetch stage.
package branch_resolve_unit_pkg;

  // Sequential fetch step: instructions are one 32-bit word each.
  localparam int unsigned PC_INC = 4;

  // Bit positions inside the sticky error vector.
  localparam int unsigned ERR_W           = 2;
  localparam int unsigned ERR_POP_EMPTY   = 0;
  localparam int unsigned ERR_PC_MISMATCH = 1;

  // Statistics counters stop at all-ones instead of wrapping.
  function automatic logic [63:0] sat_inc64(input logic [63:0] val, input logic [63:0] max_val);
    sat_inc64 = (val == max_val) ? val : val + 64'd1;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_pred_fifo.sv
// In-order prediction queue. Storage has no reset; only the pointers and
// the occupancy are reset or cleared. No data-dependent logic lives here.
module branch_resolve_unit_pred_fifo
  import branch_resolve_unit_pkg::*;
#(
  parameter int W     = 65,
  parameter int DEPTH = 4,
  parameter int PTR   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_clear,
  input  logic [W-1:0] i_wdata,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);

  logic [W-1:0]   r_mem [DEPTH];
  logic [PTR-1:0] r_wr_ptr;
  logic [PTR-1:0] r_rd_ptr;
  logic [PTR:0]   r_count;
  logic           r_full;
  logic [PTR:0]   w_count_nxt;

  // Entry storage: written at the tail on every accepted push.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Occupancy after this edge, used to register the full flag.
  always_comb begin
    w_count_nxt = r_count + (PTR+1)'(i_push) - (PTR+1)'(i_pop);
  end

  // Pointer/occupancy bookkeeping; clear wins over push and pop.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (PTR+1)'(DEPTH));
    end
  end

  assign o_full  = r_full;
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-side branch resolution: holds fetch-time predictions in order,
// checks each against the EX outcome, and drives flush/redirect, the BTB
// update strobe, sticky error flags and statistics counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int PC_BITS = 32,
  parameter int DEPTH   = 4,
  parameter int PTR     = 2,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_f_push,
  input  logic [PC_BITS-1:0] i_f_pc,
  input  logic               i_f_pred_taken,
  input  logic [PC_BITS-1:0] i_f_pred_target,
  input  logic               i_ex_adv,
  input  logic [PC_BITS-1:0] i_ex_pc,
  input  logic               i_ex_brn,
  input  logic               i_ex_true_taken,
  input  logic [PC_BITS-1:0] i_ex_alu_out,
  output logic               o_q_full,
  output logic               o_r_flush,
  output logic [PC_BITS-1:0] o_r_redirect_pc,
  output logic               o_u_brn,
  output logic [ERR_W-1:0]   o_err_sticky,
  output logic [CNT_W-1:0]   o_brn_cnt,
  output logic [CNT_W-1:0]   o_mispred_cnt
);

  localparam int ENT_W = 2*PC_BITS + 1;
  localparam logic [PC_BITS-1:0] W_INC = PC_BITS'(PC_INC);

  logic               r_flush;
  logic [PC_BITS-1:0] r_redirect_pc;
  logic [ERR_W-1:0]   r_err_sticky;
  logic [CNT_W-1:0]   r_brn_cnt;
  logic [CNT_W-1:0]   r_mispred_cnt;

  logic               w_full;
  logic               w_empty;
  logic [ENT_W-1:0]   w_head;
  logic [ENT_W-1:0]   w_wdata;
  logic [PC_BITS-1:0] w_head_pc;
  logic               w_head_pt;
  logic [PC_BITS-1:0] w_head_tgt;
  logic               w_pop_req;
  logic               w_pop;
  logic               w_pop_empty;
  logic               w_push;
  logic [PC_BITS-1:0] w_actual_next;
  logic [PC_BITS-1:0] w_pred_next;
  logic               w_mispred;
  logic               w_pc_mismatch;

  assign w_wdata = {i_f_pc, i_f_pred_taken, i_f_pred_target};
  assign {w_head_pc, w_head_pt, w_head_tgt} = w_head;

  // Queue qualification: the flush cycle carries wrong-path work, so both
  // sides are ignored then. A full queue still accepts a push when the
  // head leaves on the same edge.
  always_comb begin
    w_pop_req   = i_ex_adv & ~r_flush;
    w_pop       = w_pop_req & ~w_empty;
    w_pop_empty = w_pop_req & w_empty;
    w_push      = i_f_push & ~r_flush & (~w_full | w_pop);
  end

  // Prediction check on the head entry as it leaves.
  always_comb begin
    w_actual_next = (i_ex_brn & i_ex_true_taken) ? i_ex_alu_out : i_ex_pc + W_INC;
    w_pred_next   = w_head_pt ? w_head_tgt : w_head_pc + W_INC;
    w_mispred     = w_pop & (w_actual_next != w_pred_next);
    w_pc_mismatch = w_pop & (w_head_pc != i_ex_pc);
  end

  branch_resolve_unit_pred_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH),
    .PTR   (PTR)
  ) u_pred_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (w_mispred),
    .i_wdata (w_wdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // Flush pulse and redirect target; redirect holds its last value between flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush       <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_flush <= w_mispred;
      if (w_mispred) r_redirect_pc <= w_actual_next;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_sticky <= '0;
    end else begin
      if (w_pop_empty)   r_err_sticky[ERR_POP_EMPTY]   <= 1'b1;
      if (w_pc_mismatch) r_err_sticky[ERR_PC_MISMATCH] <= 1'b1;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_brn_cnt     <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_pop & i_ex_brn) r_brn_cnt     <= CNT_W'(sat_inc64(64'(r_brn_cnt), 64'({CNT_W{1'b1}})));
      if (w_mispred)        r_mispred_cnt <= CNT_W'(sat_inc64(64'(r_mispred_cnt), 64'({CNT_W{1'b1}})));
    end
  end

  assign o_q_full        = w_full;
  assign o_r_flush       = r_flush;
  assign o_r_redirect_pc = r_redirect_pc;
  assign o_u_brn         = i_ex_brn & i_ex_adv & ~r_flush;
  assign o_err_sticky    = r_err_sticky;
  assign o_brn_cnt       = r_brn_cnt;
  assign o_mispred_cnt   = r_mispred_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_branch_resolve_unit;

  localparam int PC_BITS = 32;
  localparam int DEPTH   = 4;
  localparam int PTR     = 2;
  localparam int CNT_W   = 3;
  localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_push = 1'b0;
  logic [31:0] f_pc = '0;
  logic        f_pt = 1'b0;
  logic [31:0] f_tgt = '0;
  logic        ex_adv = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        ex_brn = 1'b0;
  logic        ex_tk = 1'b0;
  logic [31:0] ex_alu = '0;

  logic              q_full;
  logic              r_flush;
  logic [31:0]       redirect_pc;
  logic              u_brn;
  logic [1:0]        err_sticky;
  logic [CNT_W-1:0]  brn_cnt;
  logic [CNT_W-1:0]  mispred_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  branch_resolve_unit #(
    .PC_BITS (PC_BITS),
    .DEPTH   (DEPTH),
    .PTR     (PTR),
    .CNT_W   (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_f_push        (f_push),
    .i_f_pc          (f_pc),
    .i_f_pred_taken  (f_pt),
    .i_f_pred_target (f_tgt),
    .i_ex_adv        (ex_adv),
    .i_ex_pc         (ex_pc),
    .i_ex_brn        (ex_brn),
    .i_ex_true_taken (ex_tk),
    .i_ex_alu_out    (ex_alu),
    .o_q_full        (q_full),
    .o_r_flush       (r_flush),
    .o_r_redirect_pc (redirect_pc),
    .o_u_brn         (u_brn),
    .o_err_sticky    (err_sticky),
    .o_brn_cnt       (brn_cnt),
    .o_mispred_cnt   (mispred_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state.
  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tgt;
  } ent_t;

  ent_t        mq[$];
  logic        m_flush = 1'b0;
  logic [31:0] m_redirect = '0;
  logic [1:0]  m_err = '0;
  logic [31:0] m_brn = '0;
  logic [31:0] m_mis = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: one step of the queue/flush/counter rules per clock edge.
  always @(posedge clk) begin
    ent_t        h;
    logic [31:0] actual, pred;
    bit          was_full, popped, mis;
    if (rst) begin
      mq.delete();
      m_flush = 1'b0; m_redirect = '0; m_err = '0; m_brn = '0; m_mis = '0;
      started = 1'b1;
    end else begin
      was_full = (mq.size() == DEPTH);
      popped = 1'b0;
      mis = 1'b0;
      if (ex_adv && !m_flush) begin
        if (mq.size() == 0) begin
          m_err[0] = 1'b1;
        end else begin
          h = mq.pop_front();
          popped = 1'b1;
          actual = (ex_brn && ex_tk) ? ex_alu : ex_pc + 32'd4;
          pred   = h.pt ? h.tgt : h.pc + 32'd4;
          if (h.pc != ex_pc) m_err[1] = 1'b1;
          if (ex_brn && m_brn != CNT_MAX) m_brn++;
          if (actual != pred) begin
            mis = 1'b1;
            m_redirect = actual;
            if (m_mis != CNT_MAX) m_mis++;
          end
        end
      end
      if (f_push && !m_flush && (!was_full || popped) && !mis)
        mq.push_back('{pc: f_pc, pt: f_pt, tgt: f_tgt});
      if (mis) mq.delete();
      m_flush = mis;
    end
  end

  // Per-cycle comparison away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("q_full", q_full, (mq.size() == DEPTH));
      chk("r_flush", r_flush, m_flush);
      if (m_flush) chk("redirect_pc", redirect_pc, m_redirect);
      chk("err_sticky", err_sticky, m_err);
      chk("brn_cnt", brn_cnt, m_brn);
      chk("mispred_cnt", mispred_cnt, m_mis);
      chk("u_brn", u_brn, ex_brn & ex_adv & !m_flush);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    f_push = 0; ex_adv = 0; ex_brn = 0; ex_tk = 0;
  endtask

  task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    f_push = 1; f_pc = pc; f_pt = pt; f_tgt = tgt;
  endtask

  task automatic pop(input logic [31:0] pc, input logic brn, input logic tk, input logic [31:0] alu);
    ex_adv = 1; ex_pc = pc; ex_brn = brn; ex_tk = tk; ex_alu = alu;
  endtask

  initial begin
    rst = 1; idle();
    tick(); tick();
    chk("rst_flush", r_flush, 0);
    chk("rst_redirect", redirect_pc, 0);
    chk("rst_full", q_full, 0);
    chk("rst_err", err_sticky, 0);
    rst = 0;

    // 1: non-branch, correctly predicted not-taken
    push(32'h100, 0, 32'h0); tick();
    idle(); pop(32'h100, 0, 0, 32'h0); tick();
    idle();
    chk("t1_flush", r_flush, 0);
    chk("t1_brn", brn_cnt, 0);

    // 2: taken branch, correctly predicted
    push(32'h200, 1, 32'h300); tick();
    idle(); pop(32'h200, 1, 1, 32'h300); tick();
    idle();
    chk("t2_flush", r_flush, 0);
    chk("t2_brn", brn_cnt, 1);
    chk("t2_mis", mispred_cnt, 0);

    // 3: predicted not-taken, resolves taken; younger entries discarded
    push(32'h200, 0, 32'h0); tick();
    push(32'h204, 0, 32'h0); tick();
    push(32'h208, 0, 32'h0); tick();
    idle(); pop(32'h200, 1, 1, 32'h400); tick();
    idle();
    chk("t3_flush", r_flush, 1);
    chk("t3_redirect", redirect_pc, 32'h400);
    chk("t3_mis", mispred_cnt, 1);
    tick();
    chk("t3_flush_pulse", r_flush, 0);
    chk("t3_full", q_full, 0);

    // 4: fill, drop while full, push+pop at full, drain
    for (int i = 0; i < 4; i++) begin
      push(32'h1000 + 32'(4*i), 0, 32'h0); tick();
    end
    idle();
    chk("t4_full", q_full, 1);
    push(32'h1010, 0, 32'h0); tick();
    idle();
    chk("t4_full_drop", q_full, 1);
    push(32'h1014, 0, 32'h0); pop(32'h1000, 0, 0, 32'h0); tick();
    idle();
    chk("t4_full_pushpop", q_full, 1);
    pop(32'h1004, 0, 0, 32'h0); tick();
    pop(32'h1008, 0, 0, 32'h0); tick();
    pop(32'h100c, 0, 0, 32'h0); tick();
    pop(32'h1014, 0, 0, 32'h0); tick();
    idle();
    chk("t4_drained", q_full, 0);
    chk("t4_err", err_sticky, 0);
    chk("t4_noflush", r_flush, 0);

    // 5: stale taken prediction on a non-branch, then pop while empty
    push(32'h10, 1, 32'h80); tick();
    idle(); pop(32'h10, 0, 0, 32'h0); tick();
    idle();
    chk("t5_flush", r_flush, 1);
    chk("t5_redirect", redirect_pc, 32'h14);
    chk("t5_mis", mispred_cnt, 2);
    tick();
    pop(32'h0, 0, 0, 32'h0); tick();
    idle();
    chk("t5_err", err_sticky, 2'b01);

    // 6: PC mismatch, then reset on top of a pending mispredict
    push(32'h500, 0, 32'h0); tick();
    idle(); pop(32'h504, 0, 0, 32'h0); tick();
    idle();
    chk("t6_err", err_sticky, 2'b11);
    tick();
    push(32'h600, 0, 32'h0); tick();
    idle(); pop(32'h600, 1, 1, 32'h900); rst = 1; tick();
    idle();
    chk("t6_rst_flush", r_flush, 0);
    chk("t6_rst_err", err_sticky, 0);
    chk("t6_rst_brn", brn_cnt, 0);
    chk("t6_rst_mis", mispred_cnt, 0);
    chk("t6_rst_full", q_full, 0);
    rst = 0; tick();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst    = ($urandom_range(0, 299) == 0);
      f_push = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) == 0) f_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
      else                           f_pc = 32'($urandom_range(0, 63) * 4);
      f_pt   = $urandom_range(0, 1);
      f_tgt  = ($urandom_range(0, 3) == 0) ? f_pc + 32'd4 : 32'($urandom_range(0, 63) * 4);
      ex_adv = ($urandom_range(0, 2) != 0);
      ex_brn = $urandom_range(0, 1);
      ex_tk  = $urandom_range(0, 1);
      ex_alu = 32'($urandom_range(0, 63) * 4);
      ex_pc  = 32'($urandom_range(0, 63) * 4);
      if (mq.size() != 0 && $urandom_range(0, 19) != 0) begin
        ex_pc = mq[0].pc;
        if ($urandom_range(0, 1) == 1) begin
          ex_brn = mq[0].pt | ex_brn;
          ex_tk  = mq[0].pt;
          ex_alu = mq[0].tgt;
        end
      end
      tick();
    end
    rst = 0; idle(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
